sel_decoder_pipe: RTL and testbench
===================================

// Module: sel_decoder_pipe
// PURPOSE
//  Parametrised, pipelined successor of the team's 3-to-8 select decoder.
//  - Decodes an SEL_W-bit select into an NUM_OUT-bit one-hot word (thermometer optional).
//  - Registered output with a valid/ready handshake and a 2-entry skid buffer, so it
//    drops into streaming control paths; counts out-of-range selects.
// PARAMETERS
//  SEL_W    3   select width, 1..6
//  NUM_OUT  8   output width, 2..2**SEL_W; sel >= NUM_OUT is out-of-range
//  CNT_W    8   width of the saturating error counter
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        reset, synchronous, active-high
//  in_valid   in   1        select word valid
//  in_ready   out  1        block can accept a word this cycle
//  in_sel     in   SEL_W    select value
//  in_mode    in   1        0 = one-hot, 1 = thermometer (ignored without macro)
//  out_valid  out  1        decoded word valid
//  out_ready  in   1        consumer accepts word this cycle
//  out_data   out  NUM_OUT  decoded word
//  out_err    out  1        word came from an out-of-range select
//  err_count  out  CNT_W    saturating count of accepted out-of-range selects
// BEHAVIOUR
//  - Reset (sync, active-high): out_valid=0, out_data=0, out_err=0, err_count=0, skid empty;
//    in_ready=0 while reset is high, 1 on first cycle after reset deasserts.
//  - Input transfer: in_valid & in_ready at clk edge. Output transfer: out_valid & out_ready.
//  - Latency: 1 cycle when output stage empty or draining; words never dropped, duplicated or reordered.
//  - Storage: output register + 1 skid entry. in_ready = ~skid_full (registered, no combinational
//    path from out_ready). States: EMPTY (out_valid=0), ONE (output reg full), TWO (both full).
//    EMPTY -in-> ONE; ONE -in&~out-> TWO; ONE -out&~in-> EMPTY; ONE in&out -> ONE;
//    TWO -out-> ONE (skid moves to output reg); in_ready=0 in TWO.
//  - Decode (computed on accept, stored): sel < NUM_OUT, mode 0: out_data = 1 << sel.
//    mode 1: out_data bits [sel:0] = 1, rest 0. sel >= NUM_OUT: out_data = 0, out_err = 1.
//  - out_data/out_err stable while out_valid & ~out_ready.
//  - err_count increments by 1 on each accepted out-of-range word; saturates at 2**CNT_W-1.
//  - NUM_OUT == 2**SEL_W: out_err never asserts.
//  - Reset mid-operation: all held words discarded, state returns to EMPTY next edge.
// CONFIGURATION
//  SEL_DECODER_THERMO_EN defined: in_mode honoured, thermometer output available.
//  Not defined: in_mode ignored, decode always one-hot; port kept for pin compatibility.
// STRUCTURE
//  - Package decoder_pkg: decode_mode_e {DEC_ONEHOT, DEC_THERMO}, onehot/thermo decode functions
//    parametrised by width, skid state enum {SK_EMPTY, SK_ONE, SK_TWO}.
//  - Sub-module dec_skid_buf: generic 2-entry valid/ready skid buffer, data width NUM_OUT+1
//    (decoded word + err bit); decoder logic sits in front of it.
// TESTING
//  1 Reset: drive reset 2 cycles with in_valid=1 -> out_valid=0, out_data=0, err_count=0, in_ready=0.
//  2 Sweep sel 0..7, out_ready=1, mode 0 -> out_data=8'h01,02,04..80 one cycle after each accept.
//  3 NUM_OUT=6: sel=6 then 7 -> out_data=0, out_err=1 each, err_count=2; sel=5 -> 8'h20-width, err=0.
//  4 Backpressure: out_ready=0, push sel=1,2 -> in_ready=0 after 2nd; release -> 02 then 04 in order.
//  5 THERMO_EN, mode 1, sel=3 -> out_data=8'h0F; without macro same stimulus -> 8'h08.
//  6 CNT_W=2: 5 out-of-range selects -> err_count=3 (saturated); reset mid-stream in TWO -> EMPTY.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and decode helpers for the pipelined select decoder.
// Decode helpers cover the widest supported output; callers keep the low NUM_OUT bits.
package decoder_pkg;

    localparam int unsigned DEC_MAX_W   = 64;
    localparam int unsigned DEC_SEL_MAX = 6;

    typedef enum logic {
        DEC_ONEHOT = 1'b0,
        DEC_THERMO = 1'b1
    } decode_mode_e;

    typedef enum logic [1:0] {
        SK_EMPTY,
        SK_ONE,
        SK_TWO
    } skid_state_e;

    function automatic logic [DEC_MAX_W-1:0] onehot_decode(input logic [DEC_SEL_MAX-1:0] sel);
        logic [DEC_MAX_W-1:0] v;
        v = DEC_MAX_W'(1);
        return v << sel;
    endfunction

    function automatic logic [DEC_MAX_W-1:0] thermo_decode(input logic [DEC_SEL_MAX-1:0] sel);
        logic [DEC_MAX_W-1:0] v;
        v = '1;
        return v >> (DEC_SEL_MAX'(DEC_MAX_W - 1) - sel);
    endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: output register plus one skid slot.
// in_ready depends only on registered state (and reset), never on out_ready.
module dec_skid_buf
    import decoder_pkg::*;
#(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e r_state;
    skid_state_e w_next;
    logic [W-1:0] r_out;
    logic [W-1:0] r_skid;
    logic         w_push;
    logic         w_pop;
    logic         w_load_out;
    logic         w_load_skid;
    logic         w_move;

    assign in_ready  = ~reset & (r_state != SK_TWO);
    assign out_valid = (r_state != SK_EMPTY);
    assign out_data  = r_out;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        w_next      = r_state;
        w_load_out  = 1'b0;
        w_load_skid = 1'b0;
        w_move      = 1'b0;
        case (r_state)
            SK_EMPTY: begin
                if (w_push) begin
                    w_next     = SK_ONE;
                    w_load_out = 1'b1;
                end
            end
            SK_ONE: begin
                if (w_push && w_pop) begin
                    w_load_out = 1'b1;
                end else if (w_push) begin
                    w_next      = SK_TWO;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_next = SK_EMPTY;
                end
            end
            SK_TWO: begin
                // in_ready is low here, so only a drain can happen
                if (w_pop) begin
                    w_next = SK_ONE;
                    w_move = 1'b1;
                end
            end
            default: w_next = SK_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SK_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_out) begin
                r_out <= in_data;
            end else if (w_move) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

endmodule

// File: rtl/sel_decoder_pipe.sv
// Pipelined select decoder: decode on accept, hold in a 2-entry skid buffer, count bad selects.
// Thermometer mode is available only when SEL_DECODER_THERMO_EN is defined.
module sel_decoder_pipe
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned NUM_OUT = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_data,
    output logic               out_err,
    output logic [CNT_W-1:0]   err_count
);

    localparam int unsigned DW = NUM_OUT + 1;

    decode_mode_e             w_mode;
    logic [DEC_SEL_MAX-1:0]   w_sel_ext;
    logic [DEC_MAX_W-1:0]     w_full;
    logic [NUM_OUT-1:0]       w_word;
    logic                     w_err;
    logic                     w_accept;
    logic [DW-1:0]            w_buf_out;
    logic [CNT_W-1:0]         r_err_count;

`ifdef SEL_DECODER_THERMO_EN
    assign w_mode = decode_mode_e'(in_mode);
`else
    logic w_unused_mode;
    assign w_mode        = DEC_ONEHOT;
    assign w_unused_mode = in_mode;
`endif

    assign w_sel_ext = DEC_SEL_MAX'(in_sel);
    assign w_err     = 32'(in_sel) >= 32'(NUM_OUT);

    always_comb begin
        w_full = (w_mode == DEC_THERMO) ? thermo_decode(w_sel_ext) : onehot_decode(w_sel_ext);
        w_word = w_err ? '0 : w_full[NUM_OUT-1:0];
    end

    generate
        if (NUM_OUT < DEC_MAX_W) begin : g_hi
            logic w_unused_hi;
            assign w_unused_hi = ^w_full[DEC_MAX_W-1:NUM_OUT];
        end
    endgenerate

    dec_skid_buf #(
        .W(DW)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({w_word, w_err}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (w_buf_out)
    );

    assign out_data  = w_buf_out[DW-1:1];
    assign out_err   = w_buf_out[0];
    assign w_accept  = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_accept && w_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign err_count = r_err_count;

endmodule

// File: tb/tb_sel_decoder_pipe.sv
// Directed bench for sel_decoder_pipe: an 8-output and a 6-output (2-bit counter) instance share stimulus.
// Thermometer expectation follows SEL_DECODER_THERMO_EN.
module tb_sel_decoder_pipe;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [2:0] in_sel;
    logic       in_mode;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_err;
    logic [7:0] a_out_data, a_err_count;
    logic       b_in_ready, b_out_valid, b_out_err;
    logic [5:0] b_out_data;
    logic [1:0] b_err_count;

    int unsigned checks;
    int unsigned errors;

    sel_decoder_pipe #(.SEL_W(3), .NUM_OUT(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_sel(in_sel), .in_mode(in_mode), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_err(a_out_err), .err_count(a_err_count)
    );

    sel_decoder_pipe #(.SEL_W(3), .NUM_OUT(6), .CNT_W(2)) u_dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sel(in_sel), .in_mode(in_mode), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_err(b_out_err), .err_count(b_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp8  [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [5:0] exp6  [8] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h00, 6'h00};
    logic       eerr6 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] bad_sel [5] = '{3'd6, 3'd7, 3'd6, 3'd7, 3'd6};
    logic [1:0] sat_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [7:0] thermo_exp8;
    logic [5:0] thermo_exp6;

    initial begin
        checks = 0;
        errors = 0;
`ifdef SEL_DECODER_THERMO_EN
        thermo_exp8 = 8'h0F;
        thermo_exp6 = 6'h0F;
`else
        thermo_exp8 = 8'h08;
        thermo_exp6 = 6'h08;
`endif
        reset = 1'b1; in_valid = 1'b1; in_sel = 3'd0; in_mode = 1'b0; out_ready = 1'b1;

        // Reset held two cycles with in_valid high
        tick();
        tick();
        check("rst out_valid", 32'(a_out_valid), 32'd0);
        check("rst out_data", 32'(a_out_data), 32'd0);
        check("rst err_count", 32'(a_err_count), 32'd0);
        check("rst in_ready", 32'(a_in_ready), 32'd0);
        check("rst6 out_err", 32'(b_out_err), 32'd0);

        reset = 1'b0; in_valid = 1'b0;
        #1;
        check("post-rst in_ready", 32'(a_in_ready), 32'd1);

        // One-hot sweep with consumer always ready; 6-output copy sees 6,7 out of range
        for (int s = 0; s < 8; s++) begin
            in_valid = 1'b1;
            in_sel   = 3'(s);
            tick();
            check($sformatf("sweep8 valid sel=%0d", s), 32'(a_out_valid), 32'd1);
            check($sformatf("sweep8 data sel=%0d", s), 32'(a_out_data), 32'(exp8[s]));
            check($sformatf("sweep8 err sel=%0d", s), 32'(a_out_err), 32'd0);
            check($sformatf("sweep6 data sel=%0d", s), 32'(b_out_data), 32'(exp6[s]));
            check($sformatf("sweep6 err sel=%0d", s), 32'(b_out_err), 32'(eerr6[s]));
        end
        in_valid = 1'b0;
        tick();
        check("drain out_valid", 32'(a_out_valid), 32'd0);
        check("sweep6 err_count", 32'(b_err_count), 32'd2);
        check("sweep8 err_count", 32'(a_err_count), 32'd0);

        // Backpressure: two words fill the buffer, third is refused
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd1;
        tick();
        check("bp first data", 32'(a_out_data), 32'h02);
        check("bp in_ready one", 32'(a_in_ready), 32'd1);
        in_sel = 3'd2;
        tick();
        check("bp in_ready full", 32'(a_in_ready), 32'd0);
        check("bp hold data", 32'(a_out_data), 32'h02);
        in_sel = 3'd3;
        tick();
        check("bp stall data", 32'(a_out_data), 32'h02);
        check("bp stall valid", 32'(a_out_valid), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp second data", 32'(a_out_data), 32'h04);
        check("bp second valid", 32'(a_out_valid), 32'd1);
        check("bp in_ready back", 32'(a_in_ready), 32'd1);
        tick();
        check("bp empty", 32'(a_out_valid), 32'd0);

        // Thermometer request
        in_mode = 1'b1; in_valid = 1'b1; in_sel = 3'd3;
        tick();
        check("thermo8 data", 32'(a_out_data), 32'(thermo_exp8));
        check("thermo6 data", 32'(b_out_data), 32'(thermo_exp6));
        in_valid = 1'b0; in_mode = 1'b0;
        tick();

        // Fill to TWO, then reset discards both words
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd1;
        tick();
        in_sel = 3'd2;
        tick();
        check("two in_ready", 32'(a_in_ready), 32'd0);
        in_valid = 1'b0; reset = 1'b1;
        tick();
        check("midrst out_valid", 32'(a_out_valid), 32'd0);
        check("midrst out_data", 32'(a_out_data), 32'd0);
        check("midrst in_ready", 32'(a_in_ready), 32'd0);
        check("midrst6 err_count", 32'(b_err_count), 32'd0);
        reset = 1'b0;
        #1;
        check("midrst release in_ready", 32'(a_in_ready), 32'd1);

        // Saturating 2-bit error counter
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_sel   = bad_sel[k];
            tick();
            check($sformatf("sat6 err k=%0d", k), 32'(b_out_err), 32'd1);
            check($sformatf("sat6 data k=%0d", k), 32'(b_out_data), 32'd0);
            check($sformatf("sat6 count k=%0d", k), 32'(b_err_count), 32'(sat_cnt[k]));
        end
        in_valid = 1'b0;
        tick();
        check("sat6 final count", 32'(b_err_count), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
